// File: rtl/lc3_operate_sequencer.sv
// Issue/writeback sequencer for LC-3 ADD/AND/NOT. It owns the R0-R7 register file,
// drives operands to an external ALU and commits the ALU result with N/Z/P updates.
module lc3_operate_sequencer #(
    parameter int NREG  = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic [WIDTH-1:0] OPA,
    output logic [WIDTH-1:0] OPB,
    output logic [1:0]       ALUK,
    input  logic [WIDTH-1:0] alu_out,
    output logic             wb_valid,
    output logic [2:0]       wb_dr,
    output logic [WIDTH-1:0] wb_data,
    output logic             N,
    output logic             Z,
    output logic             P,
    output logic             illegal,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [1:0] K_ADD  = 2'b00;
    localparam logic [1:0] K_AND  = 2'b01;
    localparam logic [1:0] K_NOT  = 2'b10;
    localparam logic [1:0] K_PASS = 2'b11;

    logic [1:0]       r_state;
    logic [15:0]      r_ir;
    logic [WIDTH-1:0] r_regs [NREG];

    logic             w_handshake;
    logic             w_is_operate;
    logic [WIDTH-1:0] w_imm5;
    logic             w_result_zero;

    assign instr_ready   = (r_state == S_IDLE);
    assign w_handshake   = instr_valid && instr_ready;
    assign w_is_operate  = (instr[15:12] == OP_ADD) || (instr[15:12] == OP_AND) ||
                           (instr[15:12] == OP_NOT);
    assign w_imm5        = {{(WIDTH-5){r_ir[4]}}, r_ir[4:0]};
    assign w_result_zero = (wb_data == '0);
    assign dbg_data      = r_regs[dbg_addr];

    // wb_data doubles as the captured ALU result; it is written into R[wb_dr] in WB.
    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ir     <= '0;
            OPA      <= '0;
            OPB      <= '0;
            ALUK     <= K_PASS;
            wb_valid <= 1'b0;
            wb_dr    <= '0;
            wb_data  <= '0;
            N        <= 1'b0;
            Z        <= 1'b1;
            P        <= 1'b0;
            illegal  <= 1'b0;
            // NOTE: the register file is architectural state that must read zero after reset,
            // so it is cleared here instead of being left as an uninitialised memory.
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_ir <= instr;
                        if (w_is_operate) begin
                            r_state <= S_READ;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    OPA <= r_regs[r_ir[8:6]];
                    OPB <= r_ir[5] ? w_imm5 : r_regs[r_ir[2:0]];
                    case (r_ir[15:12])
                        OP_NOT: begin
                            OPB  <= '0;
                            ALUK <= K_NOT;
                        end
                        OP_AND:  ALUK <= K_AND;
                        default: ALUK <= K_ADD;
                    endcase
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    wb_data  <= alu_out;
                    wb_dr    <= r_ir[11:9];
                    wb_valid <= 1'b1;
                    ALUK     <= K_PASS;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    r_regs[wb_dr] <= wb_data;
                    N             <= wb_data[WIDTH-1];
                    Z             <= w_result_zero;
                    P             <= !wb_data[WIDTH-1] && !w_result_zero;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
